// File: rtl/mem_arbiter_if.sv
// Signal bundle between the arbiter, its two requesters (fetch, load/store)
// and the shared memory bus.
interface mem_arbiter_if;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_flush;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        overrun;

    // Arbiter side.
    modport slave (
        input  imem_valid, imem_addr, imem_flush,
        input  dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
        input  mem_ready, mem_rdata,
        output imem_ready, imem_rdata, dmem_ready, dmem_rdata,
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output overrun
    );

    // Requesters plus memory side.
    modport master (
        output imem_valid, imem_addr, imem_flush,
        output dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
        output mem_ready, mem_rdata,
        input  imem_ready, imem_rdata, dmem_ready, dmem_rdata,
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  overrun
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: one pending slot per port, dmem priority with a
// bounded starvation count for imem, and fetch flush with response suppression.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t state, state_nxt;

    logic          i_pend, i_kill, d_pend;
    logic [31:0]   i_addr, d_addr, d_wdata;
    logic [3:0]    d_wstrb;
    logic [CW-1:0] cnt;

    logic i_live, grant_i, grant_d, done_i, done_d;
    logic i_free, d_free, i_acc, d_acc;

    // A flush in the grant cycle must keep the stale fetch off the bus.
    assign i_live = i_pend && !bus.imem_flush;

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        done_i    = 1'b0;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                if (d_pend && (!i_live || cnt < LIMIT)) begin
                    state_nxt = BUSY_D;
                    grant_d   = 1'b1;
                end else if (i_live) begin
                    state_nxt = BUSY_I;
                    grant_i   = 1'b1;
                end
            end
            BUSY_I: if (bus.mem_ready) begin
                state_nxt = IDLE;
                done_i    = 1'b1;
            end
            BUSY_D: if (bus.mem_ready) begin
                state_nxt = IDLE;
                done_d    = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // While a killed fetch is in flight the slot may already hold its redirect target.
    assign i_free = !i_pend || bus.imem_flush || (done_i && !i_kill);
    assign d_free = !d_pend || done_d;
    assign i_acc  = bus.imem_valid && i_free;
    assign d_acc  = bus.dmem_valid && d_free;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_pend         <= 1'b0;
            i_kill         <= 1'b0;
            i_addr         <= '0;
            d_pend         <= 1'b0;
            d_addr         <= '0;
            d_wdata        <= '0;
            d_wstrb        <= '0;
            cnt            <= '0;
            bus.imem_ready <= 1'b0;
            bus.imem_rdata <= '0;
            bus.dmem_ready <= 1'b0;
            bus.dmem_rdata <= '0;
            bus.mem_valid  <= 1'b0;
            bus.mem_instr  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_wstrb  <= '0;
            bus.overrun    <= 1'b0;
        end else begin
            if (done_i && !i_kill) i_pend <= 1'b0;
            if (bus.imem_flush)    i_pend <= 1'b0;
            if (i_acc) begin
                i_pend <= 1'b1;
                i_addr <= bus.imem_addr;
            end

            if (state == BUSY_I && !bus.mem_ready) i_kill <= i_kill | bus.imem_flush;
            else                                   i_kill <= 1'b0;

            if (done_d) d_pend <= 1'b0;
            if (d_acc) begin
                d_pend  <= 1'b1;
                d_addr  <= bus.dmem_addr;
                d_wdata <= bus.dmem_wdata;
                d_wstrb <= bus.dmem_wstrb;
            end

            if (!i_pend || grant_i)            cnt <= '0;
            else if (grant_d && cnt < LIMIT)   cnt <= cnt + 1'b1;

            bus.overrun <= bus.overrun | (bus.imem_valid && !i_free)
                                       | (bus.dmem_valid && !d_free);

            bus.imem_ready <= done_i && !i_kill && !bus.imem_flush;
            if (done_i && !i_kill && !bus.imem_flush) bus.imem_rdata <= bus.mem_rdata;
            bus.dmem_ready <= done_d;
            if (done_d) bus.dmem_rdata <= bus.mem_rdata;

            if (grant_d) begin
                bus.mem_valid <= 1'b1;
                bus.mem_instr <= 1'b0;
                bus.mem_addr  <= d_addr;
                bus.mem_wdata <= d_wdata;
                bus.mem_wstrb <= d_wstrb;
            end else if (grant_i) begin
                bus.mem_valid <= 1'b1;
                bus.mem_instr <= 1'b1;
                bus.mem_addr  <= i_addr;
                bus.mem_wdata <= '0;
                bus.mem_wstrb <= '0;
            end else if (done_i || done_d) begin
                bus.mem_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, same-cycle priority, starvation
// bound, fetch flush, overrun and asynchronous reset.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus();
    mem_arbiter #(.STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    logic        g_instr;
    logic [31:0] g_addr, g_wdata;
    logic [3:0]  g_wstrb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a bus request and capture its fields.
    task automatic wait_grant(input string tag);
        int n = 0;
        while (bus.mem_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(tag, {31'd0, bus.mem_valid}, 32'd1);
        g_instr = bus.mem_instr;
        g_addr  = bus.mem_addr;
        g_wdata = bus.mem_wdata;
        g_wstrb = bus.mem_wstrb;
    endtask

    // Hold one cycle, then complete with rdata; optionally re-request dmem on the completion cycle.
    task automatic complete(input logic [31:0] rdata, input bit redo_d, input logic [31:0] d_addr);
        step();
        chk("hold_valid", {31'd0, bus.mem_valid}, 32'd1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rdata;
        if (redo_d) begin
            bus.dmem_valid = 1'b1;
            bus.dmem_addr  = d_addr;
            bus.dmem_wstrb = 4'h0;
        end
        step();
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        bus.dmem_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.imem_valid = 0; bus.imem_addr = 0; bus.imem_flush = 0;
        bus.dmem_valid = 0; bus.dmem_addr = 0; bus.dmem_wdata = 0; bus.dmem_wstrb = 0;
        bus.mem_ready = 0; bus.mem_rdata = 0;
        step(); step();
        chk("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_readies", {30'd0, bus.imem_ready, bus.dmem_ready}, 32'd0);
        chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
        rst = 1'b1;
        step();

        // Fetch only
        bus.imem_valid = 1; bus.imem_addr = 32'h100;
        step();
        bus.imem_valid = 0;
        chk("f_no_early_valid", {31'd0, bus.mem_valid}, 32'd0);
        wait_grant("f_grant");
        chk("f_instr", {31'd0, g_instr}, 32'd1);
        chk("f_addr", g_addr, 32'h100);
        chk("f_wstrb", {28'd0, g_wstrb}, 32'd0);
        complete(32'h13, 0, 0);
        chk("f_iready", {31'd0, bus.imem_ready}, 32'd1);
        chk("f_irdata", bus.imem_rdata, 32'h13);
        chk("f_dready", {31'd0, bus.dmem_ready}, 32'd0);
        chk("f_valid_drop", {31'd0, bus.mem_valid}, 32'd0);
        step();
        chk("f_iready_pulse", {31'd0, bus.imem_ready}, 32'd0);

        // Same-cycle requests: dmem store first
        bus.imem_valid = 1; bus.imem_addr = 32'h200;
        bus.dmem_valid = 1; bus.dmem_addr = 32'h8000; bus.dmem_wdata = 32'hAA; bus.dmem_wstrb = 4'hF;
        step();
        bus.imem_valid = 0; bus.dmem_valid = 0; bus.dmem_wstrb = 0; bus.dmem_wdata = 0;
        wait_grant("s_grant1");
        chk("s1_instr", {31'd0, g_instr}, 32'd0);
        chk("s1_addr", g_addr, 32'h8000);
        chk("s1_wstrb", {28'd0, g_wstrb}, 32'hF);
        chk("s1_wdata", g_wdata, 32'hAA);
        complete(32'h11, 0, 0);
        chk("s1_ready", {30'd0, bus.imem_ready, bus.dmem_ready}, 32'd1);
        chk("s1_drdata", bus.dmem_rdata, 32'h11);
        wait_grant("s_grant2");
        chk("s2_instr", {31'd0, g_instr}, 32'd1);
        chk("s2_addr", g_addr, 32'h200);
        chk("s2_wstrb", {28'd0, g_wstrb}, 32'd0);
        complete(32'h22, 0, 0);
        chk("s2_ready", {30'd0, bus.imem_ready, bus.dmem_ready}, 32'd2);
        chk("s2_irdata", bus.imem_rdata, 32'h22);

        // Starvation: four dmem grants, then imem forced
        bus.imem_valid = 1; bus.imem_addr = 32'h500;
        bus.dmem_valid = 1; bus.dmem_addr = 32'h9000; bus.dmem_wstrb = 4'h0;
        step();
        bus.imem_valid = 0; bus.dmem_valid = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant("st_grant_d");
            chk("st_d_instr", {31'd0, g_instr}, 32'd0);
            complete(32'h30 + k, 1, 32'h9000 + 4 * (k + 1));
            chk("st_dready", {31'd0, bus.dmem_ready}, 32'd1);
        end
        wait_grant("st_grant_i");
        chk("st_forced_instr", {31'd0, g_instr}, 32'd1);
        chk("st_forced_addr", g_addr, 32'h500);
        complete(32'h50, 0, 0);
        chk("st_iready", {31'd0, bus.imem_ready}, 32'd1);
        wait_grant("st_grant_d5");
        chk("st_d5_addr", g_addr, 32'h9010);
        complete(32'h60, 0, 0);
        chk("st_no_overrun", {31'd0, bus.overrun}, 32'd0);

        // Flush of an in-flight fetch with redirect
        bus.imem_valid = 1; bus.imem_addr = 32'h300;
        step();
        bus.imem_valid = 0;
        wait_grant("fl_grant1");
        chk("fl_addr1", g_addr, 32'h300);
        bus.imem_flush = 1; bus.imem_valid = 1; bus.imem_addr = 32'h400;
        step();
        bus.imem_flush = 0; bus.imem_valid = 0;
        chk("fl_still_on_bus", bus.mem_addr, 32'h300);
        chk("fl_still_valid", {31'd0, bus.mem_valid}, 32'd1);
        bus.mem_ready = 1; bus.mem_rdata = 32'hDEAD;
        step();
        bus.mem_ready = 0; bus.mem_rdata = 0;
        chk("fl_suppressed", {31'd0, bus.imem_ready}, 32'd0);
        wait_grant("fl_grant2");
        chk("fl_addr2", g_addr, 32'h400);
        complete(32'h55, 0, 0);
        chk("fl_iready", {31'd0, bus.imem_ready}, 32'd1);
        chk("fl_irdata", bus.imem_rdata, 32'h55);

        // Overrun: second dmem pulse while pending
        bus.dmem_valid = 1; bus.dmem_addr = 32'hA000; bus.dmem_wstrb = 0;
        step();
        bus.dmem_addr = 32'hA004;
        step();
        bus.dmem_valid = 0;
        chk("ov_set", {31'd0, bus.overrun}, 32'd1);
        wait_grant("ov_grant");
        chk("ov_addr", g_addr, 32'hA000);
        complete(32'h77, 0, 0);
        chk("ov_dready", {31'd0, bus.dmem_ready}, 32'd1);
        step(); step(); step();
        chk("ov_single_txn", {31'd0, bus.mem_valid}, 32'd0);
        chk("ov_sticky", {31'd0, bus.overrun}, 32'd1);

        // Async reset mid BUSY_D, late mem_ready ignored
        bus.dmem_valid = 1; bus.dmem_addr = 32'hB000; bus.dmem_wdata = 32'h1234; bus.dmem_wstrb = 4'h3;
        step();
        bus.dmem_valid = 0;
        wait_grant("r_grant");
        chk("r_wstrb", {28'd0, g_wstrb}, 32'h3);
        #2 rst = 1'b0;
        #1;
        chk("r_async_valid", {31'd0, bus.mem_valid}, 32'd0);
        chk("r_async_addr", bus.mem_addr, 32'd0);
        chk("r_async_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
        chk("r_async_overrun", {31'd0, bus.overrun}, 32'd0);
        chk("r_async_drdata", bus.dmem_rdata, 32'd0);
        step();
        rst = 1'b1;
        bus.mem_ready = 1; bus.mem_rdata = 32'hBAD;
        step();
        bus.mem_ready = 0; bus.mem_rdata = 0;
        chk("r_late_ignored", {30'd0, bus.imem_ready, bus.dmem_ready}, 32'd0);
        step();
        chk("r_late_ignored2", {30'd0, bus.imem_ready, bus.dmem_ready}, 32'd0);
        chk("r_idle", {31'd0, bus.mem_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
